// File: rtl/pio_in_pkg.sv
// ============================================================================
//  Module   : pio_in_pkg
//  Purpose  : Shared constants for the debounced input PIO slave: register
//             word addresses, bus width and debounce counter width.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_in_pkg;

  // Avalon-MM data bus width
  localparam int BUS_W = 32;

  // Debounce sample counter width; holds up to DB_MAX-1 for DB_MAX <= 255
  localparam int DB_CNT_W = 8;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

endpackage

`default_nettype wire

// File: rtl/pio_debounce_ch.sv
// ============================================================================
//  Module   : pio_debounce_ch
//  Purpose  : Single-channel debounce filter. On each sample tick the
//             synchronized input is compared with the accepted level; a new
//             level is accepted after DB_MAX consecutive differing ticks.
//  Ports    : clk     - system clock
//             rst     - synchronous active-high reset
//             i_tick  - sample strobe, one cycle wide
//             i_sync  - synchronized input bit
//             o_db    - debounced level
//             o_busy  - a change is pending (sample counter non-zero)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_debounce_ch
  import pio_in_pkg::*;
#(
  parameter int   DB_MAX      = 15,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_db,
  output logic o_busy
);

  localparam logic [DB_CNT_W-1:0] C_CNT_LAST = DB_CNT_W'(DB_MAX - 1);

  logic [DB_CNT_W-1:0] r_cnt;
  logic                r_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_db  <= RESET_LEVEL;
    end else if (i_tick) begin
      if (i_sync == r_db) begin
        // Any agreeing sample restarts the run
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_db  <= i_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/pio_in_debounce_irq.sv
// ============================================================================
//  Module   : pio_in_debounce_irq
//  Purpose  : Avalon-MM input PIO with 2-flop synchronizer, per-channel
//             debounce, per-bit rising/falling edge capture (W1C) and a
//             maskable level interrupt.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             address, chipselect,
//             write_n, writedata  - Avalon-MM slave write/select
//             in_port             - asynchronous external inputs
//             readdata            - registered read data (1-cycle latency)
//             irq                 - level interrupt, active-high
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_in_debounce_irq
  import pio_in_pkg::*;
#(
  parameter int   WIDTH       = 4,
  parameter int   TICK_DIV    = 50000,
  parameter int   DB_MAX      = 15,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] r_db_q;
  logic [WIDTH-1:0] w_busy;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;
  logic [BUS_W-1:0] w_rd_mux;
  logic [BUS_W-1:0] r_readdata;
  logic             w_tick;
  logic             w_wr;

  // Shared debounce sample tick
  generate
    if (TICK_DIV == 1) begin : g_tick_const
      assign w_tick = 1'b1;
    end else begin : g_tick_cnt
      localparam int TICK_W = $clog2(TICK_DIV);
      localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);
      logic [TICK_W-1:0] r_tick_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_tick_cnt <= '0;
        end else if (r_tick_cnt == C_TICK_LAST) begin
          r_tick_cnt <= '0;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end

      assign w_tick = (r_tick_cnt == C_TICK_LAST);
    end
  endgenerate

  // Upper write-data bits have no backing register
  generate
    if (WIDTH < BUS_W) begin : g_wdata_unused
      logic w_unused_wdata;
      assign w_unused_wdata = ^writedata[BUS_W-1:WIDTH];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      pio_debounce_ch #(
        .DB_MAX      (DB_MAX),
        .RESET_LEVEL (RESET_LEVEL)
      ) u_ch (
        .clk    (clk),
        .rst    (reset),
        .i_tick (w_tick),
        .i_sync (r_d2[gi]),
        .o_db   (w_db[gi]),
        .o_busy (w_busy[gi])
      );
    end
  endgenerate

  assign w_wr   = chipselect & ~write_n;
  assign w_edge = (w_db & ~r_db_q & r_rise_en) | (~w_db & r_db_q & r_fall_en);
  assign w_w1c  = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d1       <= {WIDTH{RESET_LEVEL}};
      r_d2       <= {WIDTH{RESET_LEVEL}};
      // Matching db_q to the reset level keeps reset release edge-free
      r_db_q     <= {WIDTH{RESET_LEVEL}};
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '1;
    end else begin
      r_d1       <= in_port;
      r_d2       <= r_d1;
      r_db_q     <= w_db;
      // New edges win over a same-cycle clear so no event is lost
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge;
      if (w_wr) begin
        case (address)
          ADDR_IRQ_MASK: r_irq_mask <= writedata[WIDTH-1:0];
          ADDR_RISE_EN:  r_rise_en  <= writedata[WIDTH-1:0];
          ADDR_FALL_EN:  r_fall_en  <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_db;
      ADDR_RAW:      w_rd_mux[WIDTH-1:0] = r_d2;
      ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE:     w_rd_mux[WIDTH-1:0] = r_edge_cap;
      ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0] = r_rise_en;
      ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0] = r_fall_en;
      ADDR_STATUS:   w_rd_mux[0]         = |w_busy;
      default: ;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_in_debounce_irq.sv
// ============================================================================
//  Module   : tb_pio_in_debounce_irq
//  Purpose  : Scoreboard bench for pio_in_debounce_irq with a behavioural
//             reference model, directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_in_debounce_irq;

  localparam int W        = 4;
  localparam int TICK_DIV = 4;
  localparam int DB_MAX   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;
  logic          rd_req = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  pio_in_debounce_irq #(
    .WIDTH       (W),
    .TICK_DIV    (TICK_DIV),
    .DB_MAX      (DB_MAX),
    .RESET_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Inputs reach the filter two clocks late; a level is accepted once it
  // has differed from the accepted level for DB_MAX sample ticks in a row.
  logic [W-1:0] m_d1 = '1, m_d2 = '1, m_db = '1, m_dbq = '1;
  logic [W-1:0] m_cap = '0, m_mask = '0, m_rise = '0, m_fall = '1;
  int           m_run [W];
  int           m_cyc = 0;
  logic         m_rd_out = 1'b0;
  logic [31:0]  sb_q [$];

  logic [31:0]  mdl_exp;
  logic [W-1:0] mdl_edge, mdl_w1c;
  logic         mdl_tick, mdl_wr;
  int           mdl_busy;

  initial for (int i = 0; i < W; i++) m_run[i] = 0;

  always @(posedge clk) begin
    m_rd_out = rd_req;
    mdl_wr   = chipselect && !write_n;
    if (reset) begin
      m_d1 = '1; m_d2 = '1; m_db = '1; m_dbq = '1;
      m_cap = '0; m_mask = '0; m_rise = '0; m_fall = '1;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_cyc = 0;
      if (rd_req) sb_q.push_back(32'h0);
    end else begin
      mdl_busy = 0;
      for (int i = 0; i < W; i++) if (m_run[i] != 0) mdl_busy = 1;
      mdl_exp = 32'h0;
      case (address)
        3'd0: mdl_exp = 32'(m_db);
        3'd1: mdl_exp = 32'(m_d2);
        3'd2: mdl_exp = 32'(m_mask);
        3'd3: mdl_exp = 32'(m_cap);
        3'd4: mdl_exp = 32'(m_rise);
        3'd5: mdl_exp = 32'(m_fall);
        3'd6: mdl_exp = 32'(mdl_busy);
        default: mdl_exp = 32'h0;
      endcase
      if (rd_req) sb_q.push_back(mdl_exp);

      mdl_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc++;

      mdl_edge = 0;
      for (int i = 0; i < W; i++) begin
        if (m_db[i] && !m_dbq[i] && m_rise[i]) mdl_edge[i] = 1'b1;
        if (!m_db[i] && m_dbq[i] && m_fall[i]) mdl_edge[i] = 1'b1;
      end
      mdl_w1c = (mdl_wr && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap   = (m_cap & ~mdl_w1c) | mdl_edge;
      m_dbq   = m_db;

      if (mdl_tick) begin
        for (int i = 0; i < W; i++) begin
          if (m_d2[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DB_MAX) begin
              m_db[i]  = m_d2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end

      m_d2 = m_d1;
      m_d1 = in_port;

      if (mdl_wr) begin
        case (address)
          3'd2: m_mask = writedata[W-1:0];
          3'd4: m_rise = writedata[W-1:0];
          3'd5: m_fall = writedata[W-1:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] mon_exp;
  logic        mon_irq;

  always @(negedge clk) begin
    if (m_rd_out) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL readdata: got %08h with no expected entry queued", readdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if (readdata !== mon_exp) begin
          n_err++;
          $display("FAIL readdata @%0t: got %08h expected %08h", $time, readdata, mon_exp);
        end
      end
    end
    mon_irq = |(m_cap & m_mask);
    n_vec++;
    if (irq !== mon_irq) begin
      n_err++;
      $display("FAIL irq @%0t: got %b expected %b", $time, irq, mon_irq);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1; address = a; rd_req = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; rd_req = 1'b0;
  endtask

  task automatic timeout_fail(input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", what);
  endtask

  initial begin
    int k;
    @(negedge clk);
    rd(3'd0);                 // still in reset: readdata 0
    reset = 1'b0;
    rd(3'd5); rd(3'd0); rd(3'd3); rd(3'd2); rd(3'd6); rd(3'd7);

    // Glitch of two ticks on bit 0 is rejected
    in_port = 4'hE; idle(8);
    in_port = 4'hF; idle(6);
    rd(3'd0); rd(3'd3);
    // Long enough low is accepted and captured as a fall
    in_port = 4'hE; rd(3'd6); idle(20);
    rd(3'd0); rd(3'd3); rd(3'd1);

    // IRQ gating
    idle(2); wr(3'd2, 32'h1); idle(2);
    wr(3'd3, 32'h1); idle(2);
    in_port = 4'hF; idle(24);

    // Rising-only on bit 1
    wr(3'd4, 32'h2); wr(3'd5, 32'h0); wr(3'd3, 32'hF);
    in_port = 4'hD; idle(20); rd(3'd3); rd(3'd4); rd(3'd5);
    in_port = 4'hF; idle(20); rd(3'd3);
    in_port = 4'hB; idle(20); rd(3'd3); rd(3'd0);
    in_port = 4'hF; idle(20);

    // W1C colliding with a fall edge on bit 3
    wr(3'd5, 32'h8); wr(3'd3, 32'hF); idle(2);
    in_port = 4'h7;
    k = 0;
    while (!(m_db[3] == 1'b0 && m_dbq[3] == 1'b1) && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) timeout_fail("collision wait");
    wr(3'd3, 32'h8); rd(3'd3);
    wr(3'd3, 32'h0); rd(3'd3);
    in_port = 4'hF; idle(24);

    // Reset while bit 0 is partway through debouncing
    in_port = 4'hE;
    k = 0;
    while (m_run[0] != 2 && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) timeout_fail("partial count wait");
    rd(3'd6);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    rd(3'd0); rd(3'd3); rd(3'd5);
    for (int i = 0; i < 20; i++) rd(3'd0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rd(3'($urandom_range(0, 7)));
        4:          wr(3'($urandom_range(0, 7)), $urandom);
        5:          wr(3'd3, $urandom);
        default:    idle(1);
      endcase
    end

    idle(3);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
